// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits, even parity, 1 stop bit, 16x oversampled at eight selectable baud rates.
// Latency: Rx_VALID rises SYNC_STAGES + 1 cycles + 10.5 bit periods (+/- one sample tick) after the Rx_D start edge.
// Backpressure: none; Rx_VALID is a one-cycle pulse and the consumer must take Rx_DATA in that cycle.
module uart_receiver #(
  parameter int CLK_HZ      = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       Rx_D,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  // The synchronizer never gets fewer than two flops, whatever the parameter says.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Sample-tick divider per baud code: round(CLK_HZ / (16 * baud)).
  localparam int DIV_0 = (CLK_HZ + 8 * 300)    / (16 * 300);
  localparam int DIV_1 = (CLK_HZ + 8 * 1200)   / (16 * 1200);
  localparam int DIV_2 = (CLK_HZ + 8 * 4800)   / (16 * 4800);
  localparam int DIV_3 = (CLK_HZ + 8 * 9600)   / (16 * 9600);
  localparam int DIV_4 = (CLK_HZ + 8 * 19200)  / (16 * 19200);
  localparam int DIV_5 = (CLK_HZ + 8 * 38400)  / (16 * 38400);
  localparam int DIV_6 = (CLK_HZ + 8 * 57600)  / (16 * 57600);
  localparam int DIV_7 = (CLK_HZ + 8 * 115200) / (16 * 115200);
  localparam int CW    = $clog2(DIV_0 + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Terminal count (DIV - 1) of the tick counter for a baud code.
  function automatic logic [CW-1:0] div_m1(input logic [2:0] code);
    case (code)
      3'd0: div_m1 = CW'(DIV_0 - 1);
      3'd1: div_m1 = CW'(DIV_1 - 1);
      3'd2: div_m1 = CW'(DIV_2 - 1);
      3'd3: div_m1 = CW'(DIV_3 - 1);
      3'd4: div_m1 = CW'(DIV_4 - 1);
      3'd5: div_m1 = CW'(DIV_5 - 1);
      3'd6: div_m1 = CW'(DIV_6 - 1);
      3'd7: div_m1 = CW'(DIV_7 - 1);
    endcase
  endfunction

  logic [SYNC_N-1:0] sync_ff;
  logic              rxs;
  logic              rxs_q;
  state_t            state;
  logic [CW-1:0]     div_lat;
  logic [CW-1:0]     baud_cnt;
  logic              tick;
  logic [3:0]        tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              par_s;

  assign rxs  = sync_ff[SYNC_N-1];
  assign tick = (baud_cnt == div_lat);

  // Bring the asynchronous serial line into the clk domain; resets to the idle (high) level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[SYNC_N-2:0], Rx_D};
    end
  end

  // Frame FSM with tick generator, mid-bit sampling and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      div_lat   <= '0;
      baud_cnt  <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      par_s     <= 1'b0;
      rxs_q     <= 1'b1;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      // rxs_q tracks the line even while disabled, so a start needs a genuine high-to-low edge.
      rxs_q    <= rxs;
      if (!Rx_EN) begin
        state    <= IDLE;
        baud_cnt <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (state != IDLE) begin
          baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
        end
        case (state)
          IDLE: begin
            baud_cnt <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            // Edge, not level: a line held low after a break never re-triggers.
            if (rxs_q && !rxs) begin
              state   <= START;
              div_lat <= div_m1(baud_select);
            end
          end
          START: begin
            if (tick) begin
              if (tick_cnt == 4'd7) begin
                tick_cnt <= '0;
                state    <= rxs ? IDLE : DATA;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd15) begin
                shift   <= {rxs, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state <= PARITY;
                end
              end
            end
          end
          PARITY: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd15) begin
                par_s <= rxs;
                state <= STOP;
              end
            end
          end
          STOP: begin
            if (tick) begin
              tick_cnt <= tick_cnt + 4'd1;
              if (tick_cnt == 4'd15) begin
                Rx_DATA   <= shift;
                Rx_PERROR <= par_s ^ (^shift);
                Rx_FERROR <= !rxs;
                Rx_VALID  <= !(par_s ^ (^shift)) && rxs;
                // Leaving at mid-stop leaves half a bit to catch an immediate next start edge.
                state     <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive stage and the consumer of the transmitter's serial output: Tx_D of the transmit system connects to Rx_D here.
- Recovers 8N-even-1 frames using 16x oversampling at one of eight selectable baud rates.
- Presents each received byte with a valid pulse, plus parity and framing error flags.
- Uses the same baud_select encoding and the same 100 MHz system clock as the transmitter, so loopback benches connect the two directly.

Parameters:
CLK_HZ, 100000000, system clock frequency; sample-tick divider = round(CLK_HZ / (16 * baud))
SYNC_STAGES, 2, flops in the Rx_D synchronizer (minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
baud_select  input  3  baud code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200
Rx_EN  input  1  receiver enable; low forces idle
Rx_D  input  1  serial line, idles high
Rx_DATA  output  8  last received byte
Rx_VALID  output  1  one-cycle pulse; error-free byte is on Rx_DATA
Rx_PERROR  output  1  parity error of the last completed frame
Rx_FERROR  output  1  framing error (stop bit = 0) of the last completed frame

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-low; all state updates on rising clk.
- Reset (reset=0 at a clk edge):
  - FSM goes to IDLE; tick and bit counters are cleared.
  - Synchronizer flops are set to 1.
  - Outputs: Rx_DATA=0x00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0.
  - Reset asserted mid-frame abandons the frame; no outputs update.
- Tick generator:
  - Counter 0..DIV-1; emits a one-cycle sample tick on wrap.
  - At 100 MHz, DIV = 20833, 5208, 1302, 651, 326, 163, 109, 54 for codes 000..111.
  - baud_select is latched when leaving IDLE and held for the whole frame; changes mid-frame have no effect.
  - Tick counter restarts at 0 on the start-edge detection.
- Frame format: start(0), D0..D7 LSB first, parity, stop(1). Parity is even: parity bit = XOR(D7..D0).
- FSM (all timing uses the synchronized line rxs):
  - IDLE: waits for rxs=0 with Rx_EN=1, then goes to START.
  - START: at tick 8 (mid-bit), rxs=0 goes to DATA with tick count reset; rxs=1 is a false start and returns to IDLE with no output change.
  - DATA: samples rxs every 16 ticks (mid-bit) into a shift register, LSB first; after 8 samples goes to PARITY.
  - PARITY: samples the parity bit 16 ticks later, then goes to STOP.
  - STOP: samples the stop bit 16 ticks later. In that same cycle:
    - Rx_DATA is loaded.
    - Rx_PERROR = (parity sample != XOR(data)).
    - Rx_FERROR = (stop sample == 0).
    - Rx_VALID = 1 for exactly that cycle, only if both error flags are 0.
    - Then returns to IDLE.
- Output holding:
  - Error flags and Rx_DATA hold until the next completed frame.
  - Rx_DATA updates even on error.
- Latency: Rx_VALID rises SYNC_STAGES + 1 + 10.5 bit periods (±1 tick) after the Rx_D falling edge.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start edge immediately after the stop bit is caught.
- Stop bit held low (break): after the FERROR frame the FSM waits in IDLE and needs rxs=1 before accepting a new start edge, so it never re-triggers on a held-low line.
- Rx_EN=0: takes effect at the next clk edge. FSM goes to IDLE and the in-progress frame is discarded; outputs hold their values, and Rx_VALID=0.

Test Plan:
- Loopback with transmitter, baud 111 (bit = 864 cycles): send 0xA5 (parity 0) -> one Rx_VALID pulse 9072..9090 cycles after the start edge; Rx_DATA=0xA5, PERROR=FERROR=0.
- Direct drive, baud 011: 0x01 with parity bit 0 -> Rx_PERROR=1, Rx_VALID never pulses, Rx_DATA=0x01. Then 0x03 with parity 0 -> PERROR clears, VALID pulses.
- Frame 0x3C with stop bit 0 at baud 111 -> Rx_FERROR=1, no VALID. Line held low 20000 cycles -> no further frames. Then line high, then a valid 0x55 -> VALID pulses, FERROR=0.
- Glitch: Rx_D low 200 cycles at baud 111 (under half a bit, 432) -> FSM back in IDLE, no output change.
- Three back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three VALID pulses in order with correct data.
- Reset asserted for one clk during D4 of a frame -> outputs return to reset values, no VALID. Rx_EN deasserted mid-frame -> frame dropped. A following frame after re-enable is received correctly.
